// File: rtl/instr_decode_pkg.sv
// instr_decode_pkg
//   Shared types and field positions for the instruction decode stage.
//   - encoding_t : the four instruction encodings (A, B, C, D) in Instr[31:30]
//   - decoded_t  : one decoded entry as it sits in the output buffer
//   - regOutOfRange : checks a register index against the configured register count
package instr_decode_pkg;

    typedef enum logic [1:0] {
        ENC_A = 2'd0,
        ENC_B = 2'd1,
        ENC_C = 2'd2,
        ENC_D = 2'd3
    } encoding_t;

    // Bit positions of the fixed fields inside the 32-bit instruction word
    localparam int ENC_LSB     = 30;
    localparam int OPCODE_LSB  = 24;
    localparam int REG1_LSB    = 18;
    localparam int VARIANT_LSB = 16;
    localparam int REG2_LSB    = 8;
    localparam int OPSIZE_LSB  = 6;

    // Every immediate fits in 20 bits once it has been extended to 20 bits:
    // B is 16 bits zero-extended (bit 19 stays 0), C is 20 bits signed and
    // D is 8 bits signed. Storing this compact form keeps the buffer narrow,
    // and a single sign extension at the output is correct for all three.
    localparam int IMM_W = 20;

    typedef struct packed {
        logic             illegal;
        logic [IMM_W-1:0] imm;
        logic [1:0]       opSize;
        logic [5:0]       reg3;
        logic [5:0]       reg2;
        logic [5:0]       reg1;
        logic [1:0]       variant;
        encoding_t        enc;
        logic [5:0]       opcode;
    } decoded_t;

    // True when a register index does not exist in a file of regCount registers
    function automatic logic regOutOfRange(input logic [5:0] idx, input int regCount);
        return $unsigned({26'd0, idx}) >= $unsigned(regCount);
    endfunction

endpackage

// File: rtl/decode_fifo.sv
// decode_fifo
//   Circular buffer of DEPTH decoded entries with read/write pointers and an
//   occupancy count. The head entry reads as all zeros while the buffer is empty.
//   Ports:
//     Clock, Reset     : rising-edge clock, synchronous active-high reset
//     push, wrData     : write wrData at the tail (ignored when full)
//     pop              : drop the head entry (ignored when empty)
//     rdData           : head entry
//     full, empty      : occupancy flags, both taken straight from the count register
module decode_fifo
    import instr_decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     Clock,
    input  logic     Reset,
    input  logic     push,
    input  decoded_t wrData,
    input  logic     pop,
    output decoded_t rdData,
    output logic     full,
    output logic     empty
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    decoded_t         mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             doPush;
    logic             doPop;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = empty ? '0 : mem[rdPtr];

    // Storage has no reset: an entry is only ever read after it was written,
    // and the empty case is masked to zero above.
    always_ff @(posedge Clock) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers wrap from DEPTH-1 back to 0 so DEPTH need not be a power of two.
    // A simultaneous push and pop moves both pointers and leaves the count alone.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage
//   Flow-controlled decode stage between instruction fetch and register read.
//   Decodes a 32-bit word combinationally, buffers up to DEPTH decoded entries
//   and presents the oldest one at its outputs.
//   Ports:
//     Clock, Reset        : rising-edge clock, synchronous active-high reset
//     InValid/InReady     : input handshake, Instr is the instruction word
//     OutValid/OutReady   : output handshake for the head entry
//     Opcode, Encoding, Variant, Reg1..Reg3, OperandSize : decoded fields
//     Immediate           : immediate extended to DATA_WIDTH
//     Illegal             : a register index used by the encoding is >= REG_COUNT
//   Optional (macro INSTR_DECODE_PERF_EN):
//     DecodedCount        : number of output handshakes
//     StallCycles         : cycles with InValid high while InReady is low
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [31:0]           Instr,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [5:0]            Opcode,
    output logic [1:0]            Encoding,
    output logic [1:0]            Variant,
    output logic [5:0]            Reg1,
    output logic [5:0]            Reg2,
    output logic [5:0]            Reg3,
    output logic [1:0]            OperandSize,
    output logic [DATA_WIDTH-1:0] Immediate,
    output logic                  Illegal
`ifdef INSTR_DECODE_PERF_EN
    ,
    output logic [31:0]           DecodedCount,
    output logic [31:0]           StallCycles
`endif
);

    decoded_t          dec;
    decoded_t          head;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              push;
    logic              pop;
    logic signed [IMM_W-1:0] headImm;

    // Field extraction. Fields an encoding does not use stay at the zero
    // default so nothing leaks over from an earlier instruction. C's Reg1
    // shares bits with its immediate but is still range-checked.
    always_comb begin
        dec         = '0;
        dec.enc     = encoding_t'(Instr[ENC_LSB +: 2]);
        dec.opcode  = Instr[OPCODE_LSB +: 6];
        dec.reg1    = Instr[REG1_LSB +: 6];
        dec.variant = Instr[VARIANT_LSB +: 2];
        case (dec.enc)
            ENC_A: begin
                dec.reg2    = Instr[REG2_LSB +: 6];
                dec.reg3    = {Instr[3:0], Instr[15:14]};
                dec.opSize  = Instr[OPSIZE_LSB +: 2];
                dec.illegal = regOutOfRange(dec.reg1, REG_COUNT)
                            | regOutOfRange(dec.reg2, REG_COUNT)
                            | regOutOfRange(dec.reg3, REG_COUNT);
            end
            ENC_B: begin
                dec.imm     = {4'd0, Instr[7:0], Instr[15:8]};
                dec.illegal = regOutOfRange(dec.reg1, REG_COUNT);
            end
            ENC_C: begin
                dec.reg2    = Instr[REG2_LSB +: 6];
                dec.opSize  = Instr[OPSIZE_LSB +: 2];
                dec.imm     = {Instr[5:0], Instr[15:8], Instr[23:18]};
                dec.illegal = regOutOfRange(dec.reg1, REG_COUNT)
                            | regOutOfRange(dec.reg2, REG_COUNT);
            end
            ENC_D: begin
                dec.reg2    = Instr[REG2_LSB +: 6];
                dec.opSize  = Instr[OPSIZE_LSB +: 2];
                dec.imm     = {{12{Instr[5]}}, Instr[5:0], Instr[15:14]};
                dec.illegal = regOutOfRange(dec.reg1, REG_COUNT)
                            | regOutOfRange(dec.reg2, REG_COUNT);
            end
            default: begin
                dec.illegal = 1'b0;
            end
        endcase
    end

    // InReady depends only on the count register and Reset, never on OutReady,
    // so a full buffer cannot take a word even if the consumer pops this cycle.
    assign InReady  = !fifoFull && !Reset;
    assign OutValid = !fifoEmpty;
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;

    decode_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clock  (Clock),
        .Reset  (Reset),
        .push   (push),
        .wrData (dec),
        .pop    (pop),
        .rdData (head),
        .full   (fifoFull),
        .empty  (fifoEmpty)
    );

    assign headImm     = head.imm;
    assign Opcode      = head.opcode;
    assign Encoding    = head.enc;
    assign Variant     = head.variant;
    assign Reg1        = head.reg1;
    assign Reg2        = head.reg2;
    assign Reg3        = head.reg3;
    assign OperandSize = head.opSize;
    assign Immediate   = DATA_WIDTH'(headImm);
    assign Illegal     = head.illegal;

`ifdef INSTR_DECODE_PERF_EN
    // Free-running 32-bit counters that wrap naturally.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            DecodedCount <= '0;
            StallCycles  <= '0;
        end else begin
            if (pop) begin
                DecodedCount <= DecodedCount + 32'd1;
            end
            if (InValid && !InReady) begin
                StallCycles <= StallCycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage
//   Self-checking bench for instr_decode_stage with REG_COUNT=32, DEPTH=2.
//   Table vectors are pushed through the stage; a scoreboard queue holds the
//   expected entries in order and compares them as the stage delivers them.
//   Hand-written sequences cover reset, latency, backpressure and mid-stream reset.
//   Perf counter checks are included when INSTR_DECODE_PERF_EN is defined.
module tb_instr_decode_stage;

    localparam int DATA_WIDTH = 32;
    localparam int REG_COUNT  = 32;
    localparam int DEPTH      = 2;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [1:0]  enc;
        logic [1:0]  variant;
        logic [5:0]  reg1;
        logic [5:0]  reg2;
        logic [5:0]  reg3;
        logic [1:0]  opSize;
        logic [31:0] imm;
        logic        illegal;
    } fields_t;

    typedef struct {
        logic [31:0] instr;
        fields_t     exp;
    } vector_t;

    logic                  Clock;
    logic                  Reset;
    logic                  InValid;
    logic                  InReady;
    logic [31:0]           Instr;
    logic                  OutValid;
    logic                  OutReady;
    logic [5:0]            Opcode;
    logic [1:0]            Encoding;
    logic [1:0]            Variant;
    logic [5:0]            Reg1;
    logic [5:0]            Reg2;
    logic [5:0]            Reg3;
    logic [1:0]            OperandSize;
    logic [DATA_WIDTH-1:0] Immediate;
    logic                  Illegal;
`ifdef INSTR_DECODE_PERF_EN
    logic [31:0]           DecodedCount;
    logic [31:0]           StallCycles;
`endif

    fields_t sb[$];
    fields_t curExp;
    fields_t zeroFields;
    vector_t vectors[9];
    int      applied     = 0;
    int      miscompares = 0;

    instr_decode_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .DEPTH      (DEPTH)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .InValid      (InValid),
        .InReady      (InReady),
        .Instr        (Instr),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Opcode       (Opcode),
        .Encoding     (Encoding),
        .Variant      (Variant),
        .Reg1         (Reg1),
        .Reg2         (Reg2),
        .Reg3         (Reg3),
        .OperandSize  (OperandSize),
        .Immediate    (Immediate),
        .Illegal      (Illegal)
`ifdef INSTR_DECODE_PERF_EN
        ,
        .DecodedCount (DecodedCount),
        .StallCycles  (StallCycles)
`endif
    );

    // 10 ns clock
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic fields_t currentFields();
        fields_t f;
        f.opcode  = Opcode;
        f.enc     = Encoding;
        f.variant = Variant;
        f.reg1    = Reg1;
        f.reg2    = Reg2;
        f.reg3    = Reg3;
        f.opSize  = OperandSize;
        f.imm     = Immediate;
        f.illegal = Illegal;
        return f;
    endfunction

    task automatic checkOutput(input fields_t exp, input string name);
        fields_t act;
        act = currentFields();
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkFlag(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge. Holds the word until it is accepted
    // (bounded), then drops InValid just after the accepting edge.
    task automatic applyStimulus(input logic [31:0] instr, input fields_t exp);
        bit accepted;
        accepted = 1'b0;
        Instr    = instr;
        curExp   = exp;
        InValid  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clock);
            if (InReady) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            applied++;
            miscompares++;
            $display("[TB] FAIL acceptTimeout: got InReady 0 for 50 cycles, expected acceptance of %h", instr);
        end
        @(posedge Clock);
        #1;
        InValid = 1'b0;
    endtask

    // Waits (bounded) until every expected entry has been delivered.
    task automatic waitDrain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (sb.size() == 0) break;
            @(posedge Clock);
            #1;
        end
        checkFlag(name, sb.size(), 0);
    endtask

    // Scoreboard monitor: sampled on the falling edge, a handshake seen here
    // completes on the next rising edge. Reset flushes the expectations.
    always @(negedge Clock) begin
        if (Reset) begin
            sb.delete();
        end else begin
            if (OutValid && OutReady) begin
                if (sb.size() == 0) begin
                    applied++;
                    miscompares++;
                    $display("[TB] FAIL unexpectedOutput: got entry %h, expected no entry", currentFields());
                end else begin
                    checkOutput(sb.pop_front(), "scoreboard");
                end
            end
            if (InValid && InReady) begin
                sb.push_back(curExp);
            end
        end
    end

    initial begin
        //             instr           opcode enc   var   reg1   reg2   reg3   opsz  imm            illegal
        vectors[0] = '{32'h050D4782, '{6'd5,  2'd0, 2'd1, 6'd3,  6'd7,  6'd9,  2'd2, 32'h00000000, 1'b0}};
        vectors[1] = '{32'h4A043412, '{6'd10, 2'd1, 2'd0, 6'd1,  6'd0,  6'd0,  2'd0, 32'h00001234, 1'b0}};
        vectors[2] = '{32'hC110C23F, '{6'd1,  2'd3, 2'd0, 6'd4,  6'd2,  6'd0,  2'd0, 32'hFFFFFFFF, 1'b0}};
        vectors[3] = '{32'h82000020, '{6'd2,  2'd2, 2'd0, 6'd0,  6'd0,  6'd0,  2'd0, 32'hFFF80000, 1'b0}};
        vectors[4] = '{32'h05A04782, '{6'd5,  2'd0, 2'd0, 6'd40, 6'd7,  6'd9,  2'd2, 32'h00000000, 1'b1}};
        vectors[5] = '{32'h4A043F12, '{6'd10, 2'd1, 2'd0, 6'd1,  6'd0,  6'd0,  2'd0, 32'h0000123F, 1'b0}};
        vectors[6] = '{32'h050D478A, '{6'd5,  2'd0, 2'd1, 6'd3,  6'd7,  6'd41, 2'd2, 32'h00000000, 1'b1}};
        vectors[7] = '{32'h8B1C2A15, '{6'd11, 2'd2, 2'd0, 6'd7,  6'd42, 6'd0,  2'd0, 32'h00054A87, 1'b1}};
        vectors[8] = '{32'hC0030010, '{6'd0,  2'd3, 2'd3, 6'd0,  6'd0,  6'd0,  2'd0, 32'h00000040, 1'b0}};
        zeroFields = '0;

        Reset    = 1'b1;
        InValid  = 1'b0;
        OutReady = 1'b1;
        Instr    = 32'h0;
        curExp   = '0;

        // Reset state
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        checkFlag("resetInReady", InReady, 0);
        checkFlag("resetOutValid", OutValid, 0);
        checkOutput(zeroFields, "resetFields");
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        checkFlag("readyAfterReset", InReady, 1);
        @(posedge Clock);
        #1;

        // One-cycle latency into an empty buffer
        applyStimulus(vectors[0].instr, vectors[0].exp);
        @(negedge Clock);
        checkFlag("latencyOutValid", OutValid, 1);
        @(posedge Clock);
        #1;

        // Table of encodings, streamed back to back
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vectors[i].instr, vectors[i].exp);
        end
        waitDrain("tableDrain");
        checkFlag("idleOutValid", OutValid, 0);

        // Backpressure: two words fill the buffer, the third is blocked
        OutReady = 1'b0;
        applyStimulus(vectors[0].instr, vectors[0].exp);
        applyStimulus(vectors[1].instr, vectors[1].exp);
        Instr   = vectors[2].instr;
        curExp  = vectors[2].exp;
        InValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            checkFlag("fullInReady", InReady, 0);
            checkFlag("stallOutValid", OutValid, 1);
            checkOutput(vectors[0].exp, "headStable");
        end
        @(posedge Clock);
        #1;
        OutReady = 1'b1;
        applyStimulus(vectors[2].instr, vectors[2].exp);
        waitDrain("backpressureDrain");
`ifdef INSTR_DECODE_PERF_EN
        checkFlag("decodedCount", DecodedCount, 13);
        checkFlag("stallCycles", StallCycles, 5);
`endif

        // Reset with two entries buffered and a word offered in the reset cycle
        OutReady = 1'b0;
        applyStimulus(vectors[3].instr, vectors[3].exp);
        applyStimulus(vectors[5].instr, vectors[5].exp);
        Reset   = 1'b1;
        Instr   = vectors[7].instr;
        curExp  = vectors[7].exp;
        InValid = 1'b1;
        @(negedge Clock);
        checkFlag("resetCycleInReady", InReady, 0);
        @(posedge Clock);
        #1;
        Reset   = 1'b0;
        InValid = 1'b0;
        @(negedge Clock);
        checkFlag("postResetOutValid", OutValid, 0);
        checkOutput(zeroFields, "postResetFields");
        checkFlag("postResetInReady", InReady, 1);
        @(posedge Clock);
        #1;
        OutReady = 1'b1;
        applyStimulus(vectors[8].instr, vectors[8].exp);
        waitDrain("postResetDrain");
`ifdef INSTR_DECODE_PERF_EN
        checkFlag("decodedCountAfterReset", DecodedCount, 1);
        checkFlag("stallCyclesAfterReset", StallCycles, 0);
`endif

        repeat (2) @(posedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

    // Safety net in case a bounded wait is ever bypassed
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Pipelined, flow-controlled successor to the single-cycle opcode decoder; sits between instruction fetch and register read.
- Accepts 32-bit instruction words on a valid/ready handshake and buffers up to DEPTH decoded entries.
- Emits fully decoded fields, with immediates sign- or zero-extended to DATA_WIDTH.
- Flags register indices that are out of range for the configured register file.

Parameters:
- DATA_WIDTH, 32, width of the extended immediate output; must be ≥20.
- REG_COUNT, 64, number of architectural registers; any decoded index ≥ REG_COUNT is illegal; range 1..64.
- DEPTH, 2, output buffer entries; must be ≥2 so full throughput is sustained under backpressure.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- InValid  in  1  instruction word present
- InReady  out  1  stage can accept a word this cycle
- Instr  in  32  instruction word
- OutValid  out  1  decoded entry at the head of the buffer
- OutReady  in  1  consumer accepts the head entry
- Opcode  out  6  Instr[29:24]
- Encoding  out  2  Instr[31:30]; 0=A, 1=B, 2=C, 3=D
- Variant  out  2  Instr[17:16]
- Reg1  out  6  Instr[23:18]
- Reg2  out  6  Instr[13:8]; A/C/D only, else 0
- Reg3  out  6  {Instr[3:0], Instr[15:14]}; A only, else 0
- OperandSize  out  2  Instr[7:6]; A/C/D only, else 0
- Immediate  out  DATA_WIDTH  extended immediate; 0 for A
- Illegal  out  1  a used register index is ≥ REG_COUNT

Behaviour:
- Decode is combinational from the current Instr. Fields are captured into the buffer on an input handshake (InValid && InReady).
- Latency: a word accepted in cycle N appears at the head with OutValid=1 in cycle N+1 if the buffer was empty.
- Immediate by encoding:
  - B: zero-extended {Instr[7:0], Instr[15:8]}.
  - C: sign-extended 20-bit {Instr[5:0], Instr[15:8], Instr[23:18]}.
  - D: sign-extended 8-bit {Instr[5:0], Instr[15:14]}.
- Fields unused by an encoding are driven to 0, never held from a previous instruction.
- Illegal checks these fields:
  - A: Reg1, Reg2, Reg3.
  - B: Reg1.
  - C, D: Reg1, Reg2.
  - C's Reg1 overlaps the immediate low bits; it is still checked.
- Illegal entries are passed downstream, not dropped.
- Buffer is a circular FIFO with read/write pointers and an occupancy count of width clog2(DEPTH+1). Pointers wrap DEPTH-1 → 0.
- InReady = (count < DEPTH). It is registered-path only, with no combinational path from OutReady.
- Simultaneous push and pop when full is not allowed, since InReady=0. When count is between 0 and DEPTH, a simultaneous push and pop leaves count unchanged and both pointers advance.
- Pop when empty is ignored.
- Head outputs (all decoded fields) hold stable while OutValid=1 && OutReady=0.
- Reset values: count=0, pointers=0, OutValid=0, InReady=0 during the Reset cycle and 1 from the following cycle, all decoded outputs 0.
- Reset asserted mid-stream discards all buffered entries. The handshake in the Reset cycle is not accepted.

Optional Feature:
- Macro: INSTR_DECODE_PERF_EN.
- When defined, adds output ports DecodedCount (32-bit) and StallCycles (32-bit).
- DecodedCount increments on each output handshake.
- StallCycles increments each cycle with InValid && !InReady.
- Both counters wrap at 2^32 and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package instr_decode_pkg holds:
  - enum encoding_t {ENC_A, ENC_B, ENC_C, ENC_D}.
  - Field bit-position localparams.
  - Packed struct decoded_t carrying all decoded output fields.
- One sub-module: decode_fifo, a parametrised DEPTH × width FIFO storing decoded_t with the push/pop/count logic.
- Field extraction remains combinational in the top module.

Test Plan:
- Encoding A: Instr=0x050D4782 → next cycle OutValid=1, Opcode=5, Encoding=0, Variant=1, Reg1=3, Reg2=7, Reg3=9, OperandSize=2, Immediate=0, Illegal=0.
- Encoding B and D, DATA_WIDTH=32:
  - 0x4A043412 → Immediate=0x00001234, Reg1=1, Reg2=0.
  - 0xC110C23F → Immediate=0xFFFFFFFF, Reg1=4, Reg2=2.
- Encoding C sign extension: 0x82000020 → Immediate=0xFFF80000, Reg1=0, Reg2=0.
- REG_COUNT=32, Instr=0x05A04782 (Reg1=40) → Illegal=1; the entry is still delivered.
- Backpressure, DEPTH=2:
  - Hold OutReady=0 and push 3 words → InReady=0 after 2 accepted.
  - Head is stable across stall cycles.
  - Release OutReady → words exit in order with no loss or duplication.
  - With the perf feature enabled, StallCycles counts the blocked cycles.
- Reset mid-stream with 2 entries buffered → next cycle OutValid=0 and all outputs 0; InReady=1 the cycle after Reset deasserts.
